// File: rtl/axi_ad9364_dac_pattern_gen_pkg.sv
// Shared definitions for the AD9364 DAC pattern generator and future receive-side checkers.
// Contents: pattern mode encodings, PN16 seed and tap positions, and the PN16 next-state function.
// No ports; import with axi_ad9364_dac_pattern_gen_pkg::*.
package axi_ad9364_dac_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_ALT  = 2'd1,
    MODE_RAMP = 2'd2,
    MODE_PN16 = 2'd3
  } pat_mode_t;

  localparam logic [15:0] PN16_SEED  = 16'hFFFF;
  localparam int          PN16_TAP_A = 15;
  localparam int          PN16_TAP_B = 13;
  localparam int          PN16_TAP_C = 12;
  localparam int          PN16_TAP_D = 10;

  // Fibonacci step: shift left, feedback enters at bit 0.
  function automatic logic [15:0] pn16_next(input logic [15:0] l);
    return {l[14:0], l[PN16_TAP_A] ^ l[PN16_TAP_B] ^ l[PN16_TAP_C] ^ l[PN16_TAP_D]};
  endfunction

endpackage

// File: rtl/axi_ad9364_dac_pattern_gen_if.sv
// DAC sample bus between the pattern generator and axi_ad9364_dig_if.
// Signals: dac_valid strobe, four I/Q words, dac_r1_mode, running sample_count.
// Modports: master = generator (drives), slave = consumer (observes).
interface axi_ad9364_dac_pattern_gen_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  dac_valid;
  logic [DATA_WIDTH-1:0] dac_data_i1;
  logic [DATA_WIDTH-1:0] dac_data_q1;
  logic [DATA_WIDTH-1:0] dac_data_i2;
  logic [DATA_WIDTH-1:0] dac_data_q2;
  logic                  dac_r1_mode;
  logic [15:0]           sample_count;

  modport master (
    output dac_valid, dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2,
    output dac_r1_mode, sample_count
  );

  modport slave (
    input dac_valid, dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2,
    input dac_r1_mode, sample_count
  );
endinterface

// File: rtl/axi_ad9364_dac_pattern_gen_pn16.sv
// 16-bit Fibonacci PN16 generator with advance and reinit, shared with receive-side checkers.
// Ports: clk, rstn (async active-low), advance (one step), reinit (back to seed), state (current value).
// reinit together with advance yields the step after the seed, so a fresh sequence can be consumed in one cycle.
module axi_ad9364_pn16
  import axi_ad9364_dac_pattern_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        advance,
  input  logic        reinit,
  output logic [15:0] state
);

  logic [15:0] base;

  assign base = reinit ? PN16_SEED : state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= PN16_SEED;
    end else if (advance) begin
      state <= pn16_next(base);
    end else begin
      state <= base;
    end
  end

endmodule

// File: rtl/axi_ad9364_dac_pattern_gen.sv
// DAC test-pattern source (zero / alternating / ramp / PN16) for axi_ad9364_dig_if, 1- or 2-channel.
// Ports: clk, rstn (async active-low), enable, mode[1:0], r1_mode; dac (master modport) carries the outputs.
// One strobe every CLK_RATIO_R1/_R2 clocks while enabled; data registered one clock after the boundary.
module axi_ad9364_dac_pattern_gen
  import axi_ad9364_dac_pattern_gen_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int CLK_RATIO_R1 = 2,
  parameter int CLK_RATIO_R2 = 4,
  parameter logic [DATA_WIDTH-1:0] PAT_I_A = DATA_WIDTH'(12'o2064),
  parameter logic [DATA_WIDTH-1:0] PAT_I_B = DATA_WIDTH'(12'o4402),
  parameter logic [DATA_WIDTH-1:0] PAT_Q_A = DATA_WIDTH'(12'o1753),
  parameter logic [DATA_WIDTH-1:0] PAT_Q_B = DATA_WIDTH'(12'o1337)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic       r1_mode,
  axi_ad9364_dac_pattern_gen_if.master dac
);

  localparam int RMAX  = (CLK_RATIO_R1 > CLK_RATIO_R2) ? CLK_RATIO_R1 : CLK_RATIO_R2;
  localparam int CNT_W = $clog2(RMAX);
  localparam logic [DATA_WIDTH-1:0] HALF = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

  logic [CNT_W-1:0]      cnt;
  logic                  r1_lat;
  pat_mode_t             mode_lat;
  logic                  phase;
  logic [DATA_WIDTH-1:0] ramp;
  logic [15:0]           lfsr;

  pat_mode_t             mode_new;
  logic                  boundary;
  logic                  reinit;
  logic                  cnt_last;
  logic                  cur_phase;
  logic [DATA_WIDTH-1:0] cur_ramp;
  logic [DATA_WIDTH-1:0] ramp_hi;
  logic [15:0]           cur_lfsr;
  logic [DATA_WIDTH-1:0] nxt_i1, nxt_q1, nxt_i2, nxt_q2;

  assign mode_new = pat_mode_t'(mode);
  assign boundary = enable && (cnt == '0);
  assign reinit   = boundary && (mode_new != mode_lat);
  // At cnt == 0 this compare is never true (ratios >= 2), so a ratio change
  // latched on the boundary only governs the counting that follows it.
  assign cnt_last = (cnt == CNT_W'(r1_lat ? CLK_RATIO_R1 - 1 : CLK_RATIO_R2 - 1));

  // A mode change makes the first set of the new mode start from initial state.
  assign cur_phase = reinit ? 1'b0 : phase;
  assign cur_ramp  = reinit ? '0 : ramp;
  assign cur_lfsr  = reinit ? PN16_SEED : lfsr;
  assign ramp_hi   = cur_ramp + HALF;

  axi_ad9364_pn16 u_pn16 (
    .clk     (clk),
    .rstn    (rstn),
    .advance (boundary && (mode_new == MODE_PN16)),
    .reinit  (reinit),
    .state   (lfsr)
  );

  always_comb begin
    nxt_i1 = '0;
    nxt_q1 = '0;
    nxt_i2 = '0;
    nxt_q2 = '0;
    case (mode_new)
      MODE_ALT: begin
        nxt_i1 = cur_phase ? PAT_I_B : PAT_I_A;
        nxt_q1 = cur_phase ? PAT_Q_B : PAT_Q_A;
        nxt_i2 = nxt_i1;
        nxt_q2 = nxt_q1;
      end
      MODE_RAMP: begin
        nxt_i1 = cur_ramp;
        nxt_q1 = ~cur_ramp;
        nxt_i2 = ramp_hi;
        nxt_q2 = ~ramp_hi;
      end
      MODE_PN16: begin
        nxt_i1 = cur_lfsr[DATA_WIDTH-1:0];
        nxt_q1 = ~cur_lfsr[DATA_WIDTH-1:0];
        nxt_i2 = cur_lfsr[15 -: DATA_WIDTH];
        nxt_q2 = ~cur_lfsr[15 -: DATA_WIDTH];
      end
      default: begin
        nxt_i1 = '0;
      end
    endcase
    if (r1_mode) begin
      nxt_i2 = '0;
      nxt_q2 = '0;
    end
  end

  assign dac.dac_r1_mode = r1_lat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt              <= '0;
      r1_lat           <= 1'b0;
      mode_lat         <= MODE_ZERO;
      phase            <= 1'b0;
      ramp             <= '0;
      dac.dac_valid    <= 1'b0;
      dac.dac_data_i1  <= '0;
      dac.dac_data_q1  <= '0;
      dac.dac_data_i2  <= '0;
      dac.dac_data_q2  <= '0;
      dac.sample_count <= '0;
    end else begin
      dac.dac_valid <= boundary;
      if (!enable || cnt_last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (boundary) begin
        mode_lat         <= mode_new;
        r1_lat           <= r1_mode;
        phase            <= (mode_new == MODE_ALT) ? ~cur_phase : cur_phase;
        ramp             <= (mode_new == MODE_RAMP) ? cur_ramp + 1'b1 : cur_ramp;
        dac.dac_data_i1  <= nxt_i1;
        dac.dac_data_q1  <= nxt_q1;
        dac.dac_data_i2  <= nxt_i2;
        dac.dac_data_q2  <= nxt_q2;
        dac.sample_count <= dac.sample_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_ad9364_dac_pattern_gen.sv
// Self-checking bench for axi_ad9364_dac_pattern_gen: directed scenarios plus randomized stimulus.
// A sample-index reference model predicts every output on every cycle; literal values pin the model.
// No ports.
module tb_axi_ad9364_dac_pattern_gen;
  localparam int DW = 12;
  localparam int RA = 2;
  localparam int RB = 4;
  localparam logic [11:0] PIA = 12'o2064;
  localparam logic [11:0] PIB = 12'o4402;
  localparam logic [11:0] PQA = 12'o1753;
  localparam logic [11:0] PQB = 12'o1337;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       r1_mode = 1'b0;

  always #5 clk = ~clk;

  axi_ad9364_dac_pattern_gen_if #(.DATA_WIDTH(DW)) dac ();

  axi_ad9364_dac_pattern_gen #(
    .DATA_WIDTH(DW), .CLK_RATIO_R1(RA), .CLK_RATIO_R2(RB)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .mode(mode), .r1_mode(r1_mode), .dac(dac)
  );

  // ---------------- reference model (indexed by samples since mode start) ----------------
  int          m_cnt = 0;
  logic [1:0]  m_mode = 2'd0;
  logic        m_r1 = 1'b0;
  int unsigned m_k = 0;
  logic [15:0] m_lfsr = 16'hFFFF;
  logic        e_valid = 1'b0;
  logic [47:0] e_set = '0;
  logic [15:0] e_cnt = '0;

  function automatic logic [15:0] pn_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [47:0] model_set(input logic [1:0] md, input int unsigned k,
                                            input logic [15:0] l, input logic r1);
    logic [11:0] i1, q1, i2, q2;
    int r;
    i1 = '0; q1 = '0; i2 = '0; q2 = '0;
    case (md)
      2'd1: begin
        i1 = (k % 2 == 0) ? PIA : PIB;
        q1 = (k % 2 == 0) ? PQA : PQB;
        i2 = i1;
        q2 = q1;
      end
      2'd2: begin
        r  = int'(k % 4096);
        i1 = 12'(r);
        q1 = ~i1;
        i2 = 12'((r + 2048) % 4096);
        q2 = ~i2;
      end
      2'd3: begin
        i1 = l[11:0];
        q1 = ~i1;
        i2 = l[15:4];
        q2 = ~i2;
      end
      default: i1 = '0;
    endcase
    if (r1) begin
      i2 = '0;
      q2 = '0;
    end
    return {i1, q1, i2, q2};
  endfunction

  wire         bnd   = enable && (m_cnt == 0);
  wire         chg   = (mode != m_mode);
  wire [31:0]  k_use = chg ? 32'd0 : m_k;
  wire [15:0]  l_use = chg ? 16'hFFFF : m_lfsr;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt <= 0; m_mode <= 2'd0; m_r1 <= 1'b0; m_k <= 0; m_lfsr <= 16'hFFFF;
      e_valid <= 1'b0; e_set <= '0; e_cnt <= '0;
    end else if (bnd) begin
      m_mode  <= mode;
      m_r1    <= r1_mode;
      m_k     <= k_use + 1;
      m_lfsr  <= (mode == 2'd3) ? pn_step(l_use) : l_use;
      e_set   <= model_set(mode, k_use, l_use, r1_mode);
      e_valid <= 1'b1;
      e_cnt   <= e_cnt + 16'd1;
      m_cnt   <= 1;
    end else begin
      e_valid <= 1'b0;
      if (!enable) m_cnt <= 0;
      else m_cnt <= (m_cnt + 1 >= (m_r1 ? RA : RB)) ? 0 : m_cnt + 1;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cmp_all();
    chk("valid", 64'(dac.dac_valid), 64'(e_valid));
    chk("data", 64'({dac.dac_data_i1, dac.dac_data_q1, dac.dac_data_i2, dac.dac_data_q2}), 64'(e_set));
    chk("sample_count", 64'(dac.sample_count), 64'(e_cnt));
    chk("r1_mode", 64'(dac.dac_r1_mode), 64'(m_r1));
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
  endtask

  // Returns the number of negedges until a valid is seen (bounded).
  task automatic wait_valid(output int gap);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!dac.dac_valid && n < 64);
    if (!dac.dac_valid) chk("valid_timeout", 64'(dac.dac_valid), 64'd1);
    gap = n;
  endtask

  task automatic do_reset(input logic [1:0] md, input logic r1, input logic en);
    rstn = 1'b0;
    mode = md; r1_mode = r1; enable = en;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  int g;
  int nv;

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset_valid", 64'(dac.dac_valid), 64'd0);
    chk("reset_count", 64'(dac.sample_count), 64'd0);
    chk("reset_i1", 64'(dac.dac_data_i1), 64'd0);
    rstn = 1'b1;
    tick();

    // 1: alternating, R1
    mode = 2'd1; r1_mode = 1'b1; enable = 1'b1;
    wait_valid(g);
    chk("t1_latency", 64'(g), 64'd1);
    chk("t1_i1_a", 64'(dac.dac_data_i1), 64'(PIA));
    chk("t1_q1_a", 64'(dac.dac_data_q1), 64'(PQA));
    chk("t1_i2_zero", 64'(dac.dac_data_i2), 64'd0);
    chk("t1_r1", 64'(dac.dac_r1_mode), 64'd1);
    wait_valid(g);
    chk("t1_gap", 64'(g), 64'd2);
    chk("t1_i1_b", 64'(dac.dac_data_i1), 64'(PIB));
    chk("t1_q1_b", 64'(dac.dac_data_q1), 64'(PQB));
    wait_valid(g);
    chk("t1_i1_a2", 64'(dac.dac_data_i1), 64'(PIA));

    // 2: ramp, 2-channel, full wrap
    do_reset(2'd2, 1'b0, 1'b1);
    wait_valid(g);
    chk("t2_latency", 64'(g), 64'd1);
    chk("t2_set0", 64'({dac.dac_data_i1, dac.dac_data_q1, dac.dac_data_i2, dac.dac_data_q2}),
        64'({12'h000, 12'hFFF, 12'h800, 12'h7FF}));
    wait_valid(g);
    chk("t2_gap", 64'(g), 64'd4);
    chk("t2_i1_1", 64'(dac.dac_data_i1), 64'h001);
    chk("t2_q1_1", 64'(dac.dac_data_q1), 64'hFFE);
    for (int i = 2; i < 4096; i++) wait_valid(g);
    chk("t2_count_4096", 64'(dac.sample_count), 64'd4096);
    chk("t2_i1_last", 64'(dac.dac_data_i1), 64'hFFF);
    wait_valid(g);
    chk("t2_i1_wrap", 64'(dac.dac_data_i1), 64'h000);
    chk("t2_i2_wrap", 64'(dac.dac_data_i2), 64'h800);

    // 3: PN16 from reset
    do_reset(2'd3, 1'b0, 1'b1);
    wait_valid(g);
    chk("t3_i1_0", 64'(dac.dac_data_i1), 64'hFFF);
    chk("t3_q1_0", 64'(dac.dac_data_q1), 64'h000);
    chk("t3_i2_0", 64'(dac.dac_data_i2), 64'hFFF);
    wait_valid(g);
    chk("t3_i1_1", 64'(dac.dac_data_i1), 64'hFFE);
    chk("t3_i2_1", 64'(dac.dac_data_i2), 64'hFFF);

    // 4: mode change mid-cadence
    do_reset(2'd2, 1'b0, 1'b1);
    wait_valid(g);
    wait_valid(g);
    tick();                     // cadence counter now at 2
    mode = 2'd1;
    wait_valid(g);
    chk("t4_gap", 64'(g), 64'd3);
    chk("t4_i1_a", 64'(dac.dac_data_i1), 64'(PIA));
    chk("t4_i2_a", 64'(dac.dac_data_i2), 64'(PIA));
    wait_valid(g);
    chk("t4_gap2", 64'(g), 64'd4);
    chk("t4_q1_b", 64'(dac.dac_data_q1), 64'(PQB));

    // 5: enable gap
    do_reset(2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) wait_valid(g);
    enable = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dac.dac_valid) nv++;
    end
    chk("t5_no_valid", 64'(nv), 64'd0);
    chk("t5_hold_i1", 64'(dac.dac_data_i1), 64'd2);
    enable = 1'b1;
    wait_valid(g);
    chk("t5_latency", 64'(g), 64'd1);
    chk("t5_i1", 64'(dac.dac_data_i1), 64'd3);

    // 6: async reset mid-run
    do_reset(2'd2, 1'b0, 1'b1);
    nv = 0;
    do begin
      wait_valid(g);
      nv++;
    end while (dac.dac_data_i1 != 12'd57 && nv < 100);
    chk("t6_reach57", 64'(dac.dac_data_i1), 64'd57);
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_valid", 64'(dac.dac_valid), 64'd0);
    chk("t6_async_data", 64'({dac.dac_data_i1, dac.dac_data_q1, dac.dac_data_i2, dac.dac_data_q2}), 64'd0);
    chk("t6_async_count", 64'(dac.sample_count), 64'd0);
    tick();
    tick();
    rstn = 1'b1;
    wait_valid(g);
    chk("t6_latency", 64'(g), 64'd1);
    chk("t6_i1", 64'(dac.dac_data_i1), 64'd0);
    chk("t6_count", 64'(dac.sample_count), 64'd1);

    // Randomized stimulus against the model
    do_reset(2'($urandom_range(3)), 1'($urandom_range(1)), 1'b1);
    for (int i = 0; i < 3000; i++) begin
      tick();
      enable = ($urandom_range(99) < 85);
      if ($urandom_range(99) < 6) mode = 2'($urandom_range(3));
      if ($urandom_range(99) < 4) r1_mode = ~r1_mode;
      if ($urandom_range(399) == 0) begin
        #2 rstn = 1'b0;
        tick();
        rstn = 1'b1;
      end
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
